// File: rtl/map_pkg.sv
// Shared MAP-decoder definitions: state count, metric width, LIFO FSM encoding and
// the saturating subtract used when ALPHA_NORM_EN normalises stored metrics.
package map_pkg;
  localparam int NSTATES = 8;
  localparam int W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } lifo_state_e;

  // a - b evaluated in W+1 bits, then clamped to the signed W-bit range.
  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] diff;
    diff = {a[W-1], a} - {b[W-1], b};
    if (diff[W] != diff[W-1]) begin
      return diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return diff[W-1:0];
  endfunction
endpackage

// File: rtl/alpha_mem.sv
// Frame storage for alpha_lifo_buf: DEPTH x DW register array, one write port and
// one synchronous read port whose output register holds until the next read.
module alpha_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // The array itself is never cleared; only the read register returns to zero.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/alpha_lifo_buf.sv
// One-frame LIFO for MAP forward metrics: fills per trellis step, replays last-step-first.
// Optional macro ALPHA_NORM_EN stores each metric as sat(ai - a0).
module alpha_lifo_buf
  import map_pkg::*;
#(
  parameter int W     = map_pkg::W,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a0,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  input  logic signed [W-1:0] a3,
  input  logic signed [W-1:0] a4,
  input  logic signed [W-1:0] a5,
  input  logic signed [W-1:0] a6,
  input  logic signed [W-1:0] a7,
  input  logic                a_valid,
  input  logic                done_fwd,
  input  logic                rd_req,
  output logic signed [W-1:0] q0,
  output logic signed [W-1:0] q1,
  output logic signed [W-1:0] q2,
  output logic signed [W-1:0] q3,
  output logic signed [W-1:0] q4,
  output logic signed [W-1:0] q5,
  output logic signed [W-1:0] q6,
  output logic signed [W-1:0] q7,
  output logic                q_valid,
  output logic [AW-1:0]       q_step,
  output logic                busy,
  output logic                frame_rdy,
  output logic                ovf,
  output logic [1:0]          dbg_state
);
  localparam int DW = NSTATES * W;
  localparam logic [AW:0] FULL_PTR = (AW+1)'(DEPTH);

  // Read handshake: a read issues in any HOLD/DRAIN cycle with rd_req high; q_valid is
  // high exactly one cycle later for that read, and q0..q7/q_step hold otherwise.
  lifo_state_e   state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          q_valid_q;
  logic [AW-1:0] q_step_q;
  logic          mem_we;
  logic          rd_issue;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

`ifdef ALPHA_NORM_EN
  assign wdata = {sat_sub(a7, a0), sat_sub(a6, a0), sat_sub(a5, a0), sat_sub(a4, a0),
                  sat_sub(a3, a0), sat_sub(a2, a0), sat_sub(a1, a0), {W{1'b0}}};
`else
  assign wdata = {a7, a6, a5, a4, a3, a2, a1, a0};
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = (AW+1)'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (a_valid) begin
          if (wr_ptr_q == FULL_PTR) begin
            ovf_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
          end
        end
        // Replay starts at the newest stored entry, including one written this cycle.
        if (done_fwd) begin
          state_d  = HOLD;
          rd_ptr_d = mem_we ? wr_ptr_q[AW-1:0] : wr_ptr_q[AW-1:0] - AW'(1);
        end
      end
      HOLD, DRAIN: begin
        if (rd_req) begin
          rd_issue = 1'b1;
          if (rd_ptr_q == '0) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q - AW'(1);
            state_d  = DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      q_valid_q <= 1'b0;
      q_step_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      q_valid_q <= rd_issue;
      if (rd_issue) q_step_q <= rd_ptr_q;
    end
  end

  alpha_mem #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_mem (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(wdata),
    .re_i   (rd_issue),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  assign q0 = rdata[0*W +: W];
  assign q1 = rdata[1*W +: W];
  assign q2 = rdata[2*W +: W];
  assign q3 = rdata[3*W +: W];
  assign q4 = rdata[4*W +: W];
  assign q5 = rdata[5*W +: W];
  assign q6 = rdata[6*W +: W];
  assign q7 = rdata[7*W +: W];

  assign q_valid   = q_valid_q;
  assign q_step    = q_step_q;
  assign busy      = (state_q == FILL) || (state_q == DRAIN);
  assign frame_rdy = (state_q == HOLD);
  assign ovf       = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_alpha_lifo_buf.sv
// Directed bench for alpha_lifo_buf: stack-based frame model checked every cycle,
// plus literal expectations from hand-worked frames.
module tb_alpha_lifo_buf;
  localparam int W = 16;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] a_in [8];
  logic                a_valid, done_fwd, rd_req;
  logic signed [W-1:0] q_out [8];
  logic                q_valid;
  logic [AW-1:0]       q_step;
  logic                busy, frame_rdy, ovf;
  logic [1:0]          dbg_state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alpha_lifo_buf #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a0(a_in[0]), .a1(a_in[1]), .a2(a_in[2]), .a3(a_in[3]),
    .a4(a_in[4]), .a5(a_in[5]), .a6(a_in[6]), .a7(a_in[7]),
    .a_valid(a_valid), .done_fwd(done_fwd), .rd_req(rd_req),
    .q0(q_out[0]), .q1(q_out[1]), .q2(q_out[2]), .q3(q_out[3]),
    .q4(q_out[4]), .q5(q_out[5]), .q6(q_out[6]), .q7(q_out[7]),
    .q_valid(q_valid), .q_step(q_step), .busy(busy), .frame_rdy(frame_rdy),
    .ovf(ovf), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: the frame is a stack of steps ----------------
  logic [8*W-1:0] exp_q [$];
  int             phase;      // 0 idle, 1 filling, 2 stored, 3 draining
  logic           m_valid;
  logic [AW-1:0]  m_step;
  logic [8*W-1:0] m_data;
  logic           m_ovf;

  function automatic logic [8*W-1:0] store_word();
    logic [8*W-1:0] w;
    int v;
    for (int k = 0; k < 8; k++) begin
      v = a_in[k];
`ifdef ALPHA_NORM_EN
      v = int'(a_in[k]) - int'(a_in[0]);
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`endif
      w[k*W +: W] = v[W-1:0];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      phase = 0; m_valid = 1'b0; m_step = '0; m_data = '0; m_ovf = 1'b0;
    end else begin
      m_valid = 1'b0;
      case (phase)
        0: if (a_valid) begin exp_q.push_back(store_word()); phase = 1; end
        1: begin
          if (a_valid) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(store_word());
            else m_ovf = 1'b1;
          end
          if (done_fwd) phase = 2;
        end
        default: if (rd_req) begin
          m_step  = AW'(exp_q.size() - 1);
          m_data  = exp_q.pop_back();
          m_valid = 1'b1;
          phase   = (exp_q.size() == 0) ? 0 : 3;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [8*W-1:0] q_pk;
      for (int k = 0; k < 8; k++) q_pk[k*W +: W] = q_out[k];
      chk("model_q_valid", q_valid, m_valid);
      chk("model_q_data", q_pk, m_data);
      if (m_valid) chk("model_q_step", q_step, m_step);
      chk("model_busy", busy, (phase == 1 || phase == 3));
      chk("model_frame_rdy", frame_rdy, (phase == 2));
      chk("model_ovf", ovf, m_ovf);
      chk("model_state", dbg_state, phase[1:0]);
    end
  end

  // ---------------- drivers ----------------
  task automatic set_data(input int s);
    a_in[0] = W'(s * 10);
    for (int k = 1; k < 7; k++) a_in[k] = W'(s * 16 + k);
    a_in[7] = W'(-s);
  endtask

  // Drive one cycle from a negedge; returns at the next negedge. s < 0 keeps a_in.
  task automatic cyc(input bit av, input bit d, input bit rr, input int s);
    a_valid = av; done_fwd = d; rd_req = rr;
    if (s >= 0) set_data(s);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; done_fwd = 1'b0; rd_req = 1'b0;
    set_data(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_q_valid", q_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", dbg_state, 0);
    chk("reset_q0", q_out[0], 0);

    // 5-step frame replayed with rd_req held high
    for (int s = 0; s < 5; s++) cyc(1, 0, 0, s);
    cyc(0, 1, 0, 0);
    chk("t1_frame_rdy", frame_rdy, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      chk("t1_q_valid", q_valid, 1);
      chk("t1_q_step", q_step, AW'(4 - i));
      chk("t1_q0", q_out[0], W'((4 - i) * 10));
      chk("t1_q7", q_out[7], W'(i - 4));
    end
    cyc(0, 0, 0, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_state", dbg_state, 0);
    chk("t1_idle_q_valid", q_valid, 0);

    // done_fwd and rd_req alone in IDLE are ignored
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("idle_ignore_state", dbg_state, 0);
    chk("idle_ignore_q_valid", q_valid, 0);

    // write and done_fwd in the same cycle
    cyc(1, 0, 0, 10);
    cyc(1, 0, 0, 11);
    cyc(1, 1, 0, 12);
    chk("t2_frame_rdy", frame_rdy, 1);
    cyc(0, 0, 1, 0);
    chk("t2_first_step", q_step, 2);
    chk("t2_first_q0", q_out[0], 120);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // overflow: 65 writes into 64 entries
    for (int s = 0; s < 65; s++) cyc(1, 0, 0, s);
    chk("t3_ovf", ovf, 1);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, 1, 0);
      if (i == 0) begin
        chk("t3_first_step", q_step, 63);
        chk("t3_first_q0", q_out[0], 630);
      end
      if (i == 63) chk("t3_last_step", q_step, 0);
    end
    cyc(0, 0, 0, 0);
    chk("t3_ovf_sticky", ovf, 1);
    chk("t3_idle_state", dbg_state, 0);

    // toggled rd_req during drain
    for (int s = 20; s < 23; s++) cyc(1, 0, 0, s);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t4_v0", q_valid, 0);
    cyc(0, 0, 1, 0);
    chk("t4_v1", q_valid, 1);
    chk("t4_step2", q_step, 2);
    cyc(0, 0, 0, 0);
    chk("t4_v2", q_valid, 0);
    chk("t4_step_hold", q_step, 2);
    cyc(0, 0, 1, 0);
    chk("t4_v3", q_valid, 1);
    chk("t4_step1", q_step, 1);
    cyc(0, 0, 1, 0);
    chk("t4_step0", q_step, 0);
    cyc(0, 0, 0, 0);

    // reset mid-drain, then a fresh frame
    for (int s = 30; s < 34; s++) cyc(1, 0, 0, s);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("t5_q_valid", q_valid, 0);
    chk("t5_q_step", q_step, 0);
    chk("t5_q0", q_out[0], 0);
    chk("t5_q7", q_out[7], 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf_cleared", ovf, 0);
    chk("t5_state", dbg_state, 0);
    for (int s = 40; s < 43; s++) cyc(1, 0, 0, s);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("t5_fresh_step", q_step, 2);
    chk("t5_fresh_q0", q_out[0], 420);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

`ifdef ALPHA_NORM_EN
    // normalisation with saturation in both directions
    for (int k = 0; k < 8; k++) a_in[k] = '0;
    a_in[0] = -16'sd32000; a_in[1] = 16'sd32000;
    cyc(1, 0, 0, -1);
    a_in[0] = 16'sd32000; a_in[1] = -16'sd32000;
    cyc(1, 1, 0, -1);
    cyc(0, 0, 1, -1);
    chk("norm_neg_sat_q1", q_out[1], 16'h8000);
    chk("norm_q0_zero_b", q_out[0], 0);
    cyc(0, 0, 1, -1);
    chk("norm_pos_sat_q1", q_out[1], 16'h7fff);
    chk("norm_q0_zero_a", q_out[0], 0);
    chk("norm_q2", q_out[2], 32000);
    cyc(0, 0, 0, 0);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
